seq_mult_shift_add: RTL and testbench
=====================================

Name: seq_mult_shift_add

Overview:
- Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Consumes a 2*WIDTH-bit ripple-carry adder datapath: each cycle it feeds the running partial product and the shifted multiplicand into the adder and registers the sum.
- Sits between the operand source and the result consumer, with a valid/ready handshake on each side. One operation in flight at a time.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, unsigned.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Reset values (rst_n low):
  - state = IDLE, counter = 0.
  - acc, mcand, mplier = 0.
  - product = 0, out_valid = 0, busy = 0.
  - in_ready = 1, since in_ready is combinational (state==IDLE).
- FSM IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid && in_ready.
  - On accept: mcand <= {WIDTH'b0, a}, mplier <= b, acc <= 0, count <= 0, go to BUSY.
  - a and b are sampled only at accept and may change afterwards.
- FSM BUSY:
  - in_ready=0.
  - Every edge: if mplier[0], acc <= acc + mcand (2*WIDTH-bit add, cin=0, cout discarded; it cannot be set for a valid product). Otherwise acc holds.
  - Same edge: mcand <= mcand << 1, mplier <= mplier >> 1, count <= count+1.
  - On the edge where count == WIDTH-1, the last iteration completes and the state goes to DONE.
  - No early termination; latency is fixed.
- FSM DONE:
  - out_valid=1 and product=acc, both held stable until out_ready.
  - On the edge with out_ready: go to IDLE, out_valid falls.
  - in_ready stays 0 in DONE; the next accept is no earlier than the edge after the output handshake.
- Latency: if accept occurs at edge k, out_valid is high after edge k+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles when out_ready is held high.
- product is a registered copy of acc. It is only meaningful while out_valid=1, and it holds its last value in IDLE.
- in_valid in BUSY/DONE is ignored; no operands are dropped because in_ready=0.
- Reset mid-operation (BUSY or DONE): the operation is aborted, all outputs return to reset values, and no product is emitted.
- Arithmetic: purely unsigned. a=0 or b=0 gives product 0 after the full WIDTH cycles.

Decomposition:
- Package mult_pkg holds:
  - WIDTH default.
  - typedef enum state_t {IDLE, BUSY, DONE}.
  - CNT_W derivation.
- One sub-module: rca_2w, a combinational 2*WIDTH-bit ripple-carry adder (A, B, cin, S, cout).
  - Instantiated once with A=acc, B=mcand, cin=0.
  - The register update muxes on mplier[0].
- FSM, counter and shift registers live in the top module.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> in_ready=1, out_valid=0, busy=0, product=0.
- Basic: a=3, b=5, accept at edge k, out_ready=1 -> out_valid high after edge k+32, product=15, in_ready back to 1 one edge later.
- Max operands: a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 after 32 cycles; no spurious high bits.
- Backpressure: a=0x12345678, b=0x9ABCDEF0, out_ready=0 for 10 cycles after out_valid -> product stays 0x0B00EA4E242D2080 with out_valid held; in_valid asserted meanwhile is not accepted.
- Zero and back-to-back: (0, 0xDEADBEEF) then (0xFFFF, 0x10000) with in_valid held high -> products 0 then 0xFFFF0000, accepts exactly WIDTH+2 cycles apart.
- Reset mid-op: accept a=7, b=9, drop rst_n at BUSY cycle 10 -> out_valid never asserts for that operation; after release a new op 2*3 yields 6.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; never below one bit so WIDTH=1 still elaborates.
  function automatic int cnt_w_of(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/rca_2w.sv
// Combinational ripple-carry adder used as the multiplier's accumulate datapath.
module rca_2w #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic carry;

  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Unsigned WIDTH x WIDTH sequential multiplier: one shift-and-add step per cycle,
// valid/ready on both sides, one operation in flight.
module seq_mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_w_of(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   sum;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic                 unused_cout;

  rca_2w #(.N(2*WIDTH)) u_rca (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .s    (sum),
    .cout (unused_cout)
  );

  assign acc_nxt   = mplier[0] ? sum : acc;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          acc    <= '0;
          count  <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // Capture the final sum on the same edge so product is valid with out_valid.
          if (count == LAST) begin
            product <= acc_nxt;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Randomized self-checking bench: products compared against plain 64-bit multiplication.
module tb_seq_mult_shift_add;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  logic ov_q = 1'b0;
  logic [2*W-1:0] sb[$];
  int acc_edges[$];

  seq_mult_shift_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted pair queues a*b; every output handshake pops one.
  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(64'(a) * 64'(b));
        acc_edges.push_back(cyc);
        last_acc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 64'(1), 64'(0));
        else chk("product", product, sb.pop_front());
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_q) chk("latency", 64'(cyc - 1 - last_acc), 64'(W));
    ov_q = out_valid;
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int stall);
    logic [2*W-1:0] exp;
    int n;
    exp = 64'(av) * 64'(bv);
    wait_idle();
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < W + 8);
    if (!out_valid) begin
      chk("out_timeout", 64'(0), 64'(1));
      out_ready = 1'b1;
      return;
    end
    if (stall > 0) begin
      in_valid = 1'b1;
      repeat (stall) begin
        chk("bp_valid", 64'(out_valid), 64'(1));
        chk("bp_prod", product, exp);
        chk("bp_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_valid", 64'(out_valid), 64'(0));
    chk("post_ready", 64'(in_ready), 64'(1));
    chk("hold_prod", product, exp);
  endtask

  initial begin
    int base, n, seen;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_prod", product, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));

    do_op(32'd3, 32'd5, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 10);

    // Back-to-back with in_valid held: second accept must land W+2 edges later.
    wait_idle();
    base = acc_edges.size();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h0; b = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    a = 32'h0000_FFFF; b = 32'h0001_0000;
    n = 0;
    while (acc_edges.size() < base + 2 && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (acc_edges.size() < base + 2) chk("b2b_timeout", 64'(0), 64'(1));
    else chk("b2b_ii", 64'(acc_edges[base+1] - acc_edges[base]), 64'(W + 2));
    repeat (W + 4) @(negedge clk);

    // Abort mid-operation.
    wait_idle();
    in_valid = 1'b1; a = 32'd7; b = 32'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ready", 64'(in_ready), 64'(1));
    chk("abort_prod", product, 64'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_out", 64'(seen), 64'(0));
    do_op(32'd2, 32'd3, 0);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = '1;
        default: rb = $urandom;
      endcase
      do_op(ra, rb, $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
